// File: rtl/dual_mem_arbiter.sv
// dual_mem_arbiter
//  Shares one dual-port RAM (RAM_WIDTH x RAM_DEPTH) between NUM_REQ requesters.
//  The write port and the read port each have their own arbiter, and both
//  arbiters decide every cycle. After reset the block zero-fills the whole RAM,
//  and it issues no grant until that sweep is finished. Read data comes back
//  tagged with the requester id, one cycle after the grant.
//
//  Optional feature macro: DUAL_MEM_ARB_RR_EN
//   defined   : each port arbitrates round-robin with its own priority pointer
//   undefined : fixed priority, lowest index wins, no pointers
//
//  Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   wr_req/wr_addr/wr_data  per-requester write requests (flattened, slice i = requester i)
//   wr_gnt                  combinational one-hot write grant
//   rd_req/rd_addr          per-requester read requests (flattened)
//   rd_gnt                  combinational one-hot read grant
//   rd_rsp_valid/rd_rsp_id  registered read response qualifier and owner
//   rd_rsp_data             RAM read data passed straight through
//   init_done               high once the zero-fill sweep is complete
//   ram_*                   RAM control/data; ram_data_out is the RAM read data
module dual_mem_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned RAM_WIDTH = 64,
  parameter int unsigned RAM_DEPTH = 1024,
  parameter int unsigned ADDR_SIZE = 10,
  parameter int unsigned ID_W      = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             wr_req,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]   wr_addr,
  input  logic [NUM_REQ*RAM_WIDTH-1:0]   wr_data,
  output logic [NUM_REQ-1:0]             wr_gnt,
  input  logic [NUM_REQ-1:0]             rd_req,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]   rd_addr,
  output logic [NUM_REQ-1:0]             rd_gnt,
  output logic                           rd_rsp_valid,
  output logic [ID_W-1:0]                rd_rsp_id,
  output logic [RAM_WIDTH-1:0]           rd_rsp_data,
  output logic                           init_done,
  output logic                           ram_mem_en,
  output logic                           ram_write,
  output logic [ADDR_SIZE-1:0]           ram_wr_address,
  output logic [RAM_WIDTH-1:0]           ram_data_in,
  output logic                           ram_op_en,
  output logic                           ram_read,
  output logic [ADDR_SIZE-1:0]           ram_rd_address,
  input  logic [RAM_WIDTH-1:0]           ram_data_out
);

  localparam int unsigned LAST_ADDR = RAM_DEPTH - 1;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] init_cnt_q, init_cnt_d;
  logic                 init_done_q, init_done_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;

  // Returns {found, index}: first requester found scanning from ptr upward with wrap.
  function automatic logic [ID_W:0] pick(input logic [NUM_REQ-1:0] req,
                                         input logic [ID_W-1:0]    ptr);
    logic [ID_W:0] res;
    int unsigned   idx;
    res = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!res[ID_W] && req[ID_W'(idx)]) res = {1'b1, ID_W'(idx)};
    end
    return res;
  endfunction

  // Slot after the winner, modulo NUM_REQ.
  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] idx);
    return (32'(idx) == NUM_REQ - 1) ? '0 : ID_W'(idx + ID_W'(1));
  endfunction

  // Unpack the flattened request buses.
  logic [ADDR_SIZE-1:0] wr_addr_a [NUM_REQ];
  logic [RAM_WIDTH-1:0] wr_data_a [NUM_REQ];
  logic [ADDR_SIZE-1:0] rd_addr_a [NUM_REQ];

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      wr_addr_a[i] = wr_addr[i*ADDR_SIZE +: ADDR_SIZE];
      wr_data_a[i] = wr_data[i*RAM_WIDTH +: RAM_WIDTH];
      rd_addr_a[i] = rd_addr[i*ADDR_SIZE +: ADDR_SIZE];
    end
  end

  logic [ID_W:0]   wr_pick, rd_pick;
  logic            wr_found, rd_found;
  logic [ID_W-1:0] wr_idx, rd_idx;

`ifdef DUAL_MEM_ARB_RR_EN
  logic [ID_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  assign wr_pick = pick(wr_req, wr_ptr_q);
  assign rd_pick = pick(rd_req, rd_ptr_q);
`else
  assign wr_pick = pick(wr_req, ID_W'(0));
  assign rd_pick = pick(rd_req, ID_W'(0));
`endif

  assign wr_found = wr_pick[ID_W];
  assign wr_idx   = wr_pick[ID_W-1:0];
  assign rd_found = rd_pick[ID_W];
  assign rd_idx   = rd_pick[ID_W-1:0];

  // State register and response/pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
`ifdef DUAL_MEM_ARB_RR_EN
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
`ifdef DUAL_MEM_ARB_RR_EN
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
`endif
    end
  end

  // Next state, grants and RAM controls.
  always_comb begin
    state_d        = state_q;
    init_cnt_d     = init_cnt_q;
    init_done_d    = init_done_q;
    rsp_valid_d    = 1'b0;
    rsp_id_d       = rsp_id_q;
    wr_gnt         = '0;
    rd_gnt         = '0;
    ram_mem_en     = 1'b1;
    ram_write      = 1'b0;
    ram_wr_address = '0;
    ram_data_in    = '0;
    ram_read       = 1'b0;
    ram_rd_address = '0;
`ifdef DUAL_MEM_ARB_RR_EN
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
`endif
    unique case (state_q)
      ST_INIT: begin
        // Zero-fill sweep; requests are ignored until it completes.
        ram_write      = 1'b1;
        ram_wr_address = init_cnt_q;
        init_cnt_d     = init_cnt_q + 1'b1;
        if (init_cnt_q == ADDR_SIZE'(LAST_ADDR)) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (wr_found) begin
          wr_gnt         = NUM_REQ'(1) << wr_idx;
          ram_write      = 1'b1;
          ram_wr_address = wr_addr_a[wr_idx];
          ram_data_in    = wr_data_a[wr_idx];
`ifdef DUAL_MEM_ARB_RR_EN
          wr_ptr_d       = next_ptr(wr_idx);
`endif
        end
        if (rd_found) begin
          rd_gnt         = NUM_REQ'(1) << rd_idx;
          ram_read       = 1'b1;
          ram_rd_address = rd_addr_a[rd_idx];
          rsp_valid_d    = 1'b1;
          rsp_id_d       = rd_idx;
`ifdef DUAL_MEM_ARB_RR_EN
          rd_ptr_d       = next_ptr(rd_idx);
`endif
        end
      end
    endcase
  end

  assign init_done    = init_done_q;
  assign ram_op_en    = init_done_q;
  assign rd_rsp_valid = rsp_valid_q;
  assign rd_rsp_id    = rsp_id_q;
  assign rd_rsp_data  = ram_data_out;

endmodule
